// File: rtl/deaccumulate_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
// Widths, FSM state encoding and seven-segment glyphs live here.
package deaccumulate_pkg;

    localparam int DVD_W = 10;
    localparam int DVS_W = 5;
    localparam int QUO_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] GLYPH_RUN  = 7'h03;
    localparam logic [6:0] GLYPH_DONE = 7'h21;
    localparam logic [6:0] GLYPH_ERR  = 7'h06;

    function automatic logic [6:0] status_glyph(input state_t s);
        case (s)
            RUN:     status_glyph = GLYPH_RUN;
            DONE:    status_glyph = GLYPH_DONE;
            ERR:     status_glyph = GLYPH_ERR;
            default: status_glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/hex7seg.sv
// 4-bit value to active-low seven-segment pattern; purely combinational.
module hex7seg (
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_val)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            default: o_seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/deaccumulate.sv
// Divider by repeated subtraction: KEY[1] loads dividend, KEY[2] loads divisor and starts.
// DEACCUMULATE_HEX_EN adds hex readout of R and Q on HEX0..HEX4; otherwise they stay dark.
module deaccumulate
    import deaccumulate_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic [2:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    logic             w_rst_n;
    logic [1:0]       r_key_s1;
    logic [1:0]       r_key_s2;
    logic [1:0]       r_key_s3;
    logic [1:0]       w_press;
    state_t           r_state;
    logic [DVD_W-1:0] r_dvd;
    logic [DVS_W-1:0] r_dvs;
    logic [DVD_W-1:0] r_rem;
    logic [QUO_W-1:0] r_quo;
    logic [DVD_W-1:0] w_dvs_ext;

    assign w_rst_n   = KEY[0];
    assign w_dvs_ext = {{(DVD_W-DVS_W){1'b0}}, r_dvs};
    // Buttons are active-low: a press is a 1->0 transition after synchronisation
    assign w_press   = r_key_s3 & ~r_key_s2;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_key_s3 <= '0;
        end else begin
            r_key_s1 <= KEY[2:1];
            r_key_s2 <= r_key_s1;
            r_key_s3 <= r_key_s2;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
        end else if (r_state == RUN) begin
            if (r_rem >= w_dvs_ext) begin
                r_rem <= r_rem - w_dvs_ext;
                r_quo <= r_quo + 1'b1;
            end else begin
                r_state <= DONE;
            end
        end else begin
            if (w_press[0])
                r_dvd <= SW[DVD_W-1:0];
            // Start uses the dividend held before this cycle, even if KEY[1] fires together
            if (w_press[1]) begin
                r_dvs   <= SW[DVS_W-1:0];
                r_rem   <= r_dvd;
                r_quo   <= '0;
                r_state <= (SW[DVS_W-1:0] == '0) ? ERR : RUN;
            end
        end
    end

    assign LEDR = r_quo;
    assign HEX5 = status_glyph(r_state);

`ifdef DEACCUMULATE_HEX_EN
    hex7seg u_hex0 (.i_val(r_rem[3:0]),          .o_seg(HEX0));
    hex7seg u_hex1 (.i_val(r_rem[7:4]),          .o_seg(HEX1));
    hex7seg u_hex2 (.i_val(r_quo[3:0]),          .o_seg(HEX2));
    hex7seg u_hex3 (.i_val(r_quo[7:4]),          .o_seg(HEX3));
    hex7seg u_hex4 (.i_val({2'b00, r_quo[9:8]}), .o_seg(HEX4));
`else
    assign HEX0 = SEG_BLANK;
    assign HEX1 = SEG_BLANK;
    assign HEX2 = SEG_BLANK;
    assign HEX3 = SEG_BLANK;
    assign HEX4 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_deaccumulate.sv
// Bench for deaccumulate: directed corner cases plus random divisions against an arithmetic model.
module tb_deaccumulate;

    localparam logic [6:0] T_BLANK = 7'h7F;
    localparam logic [6:0] T_RUN   = 7'h03;
    localparam logic [6:0] T_DONE  = 7'h21;
    localparam logic [6:0] T_ERR   = 7'h06;

    logic       CLOCK_50 = 1'b0;
    logic [2:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_total = 0;
    int n_bad   = 0;
    int run_cnt = 0;

    deaccumulate dut (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50)
        if (HEX5 == T_RUN) run_cnt = run_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

`ifdef DEACCUMULATE_HEX_EN
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[v];
    endfunction
`endif

    task automatic chk_rem(input string tag, input int exp_r);
        logic [9:0] r;
        r = exp_r[9:0];
`ifdef DEACCUMULATE_HEX_EN
        chk({tag, "_rhex"}, {HEX1, HEX0}, {seg_of(r[7:4]), seg_of(r[3:0])});
`else
        chk({tag, "_r"}, dut.r_rem, r);
        chk({tag, "_hexoff"}, {HEX4, HEX3, HEX2, HEX1, HEX0}, {5{T_BLANK}});
`endif
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press(input int idx);
        @(negedge CLOCK_50);
        KEY[idx] = 1'b0;
        cycles(5);
        KEY[idx] = 1'b1;
        cycles(5);
    endtask

    task automatic wait_end(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (HEX5 == T_DONE || HEX5 == T_ERR) begin
                seen = 1;
                break;
            end
            @(negedge CLOCK_50);
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    // Reference: plain integer division; RUN lasts quotient+1 cycles
    task automatic do_div(input string tag, input int dvd, input int dvs);
        int eq, er;
        eq = dvd / dvs;
        er = dvd % dvs;
        SW = dvd[9:0];
        press(1);
        SW = dvs[9:0];
        run_cnt = 0;
        press(2);
        wait_end(tag);
        cycles(2);
        chk({tag, "_q"}, LEDR, eq);
        chk_rem(tag, er);
        chk({tag, "_cyc"}, run_cnt, eq + 1);
        chk({tag, "_st"}, HEX5, T_DONE);
    endtask

    initial begin
        int a, b;
        KEY = 3'b110;
        SW  = '0;
        #1;
        chk("rst_q", LEDR, 0);
        chk("rst_st", HEX5, T_BLANK);
        chk("rst_hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, {5{T_BLANK}});
        cycles(3);
        KEY[0] = 1'b1;
        cycles(3);

        do_div("d100_7", 100, 7);
        do_div("d5_9", 5, 9);
        do_div("d1023_1", 1023, 1);

        // Divisor zero goes to ERR with R = dividend
        SW = 10'd77;
        press(1);
        SW = 10'd0;
        press(2);
        cycles(2);
        chk("err_st", HEX5, T_ERR);
        chk("err_q", LEDR, 0);
        chk_rem("err", 77);
        cycles(10);
        chk("err_hold", HEX5, T_ERR);
        do_div("d9_3", 9, 3);

        // Presses during RUN must be ignored, including the dividend load
        SW = 10'd500;
        press(1);
        SW = 10'd2;
        run_cnt = 0;
        press(2);
        SW = 10'd7;
        press(1);
        SW = 10'd5;
        press(2);
        wait_end("busy");
        cycles(2);
        chk("busy_q", LEDR, 250);
        chk_rem("busy", 0);
        chk("busy_cyc", run_cnt, 251);
        SW = 10'd2;
        press(2);
        wait_end("busy2");
        cycles(2);
        chk("busy2_q", LEDR, 250);

        // Asynchronous reset in the middle of a run
        SW = 10'd1023;
        press(1);
        SW = 10'd1;
        press(2);
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 2000; i++) begin
                if (LEDR == 10'd40) begin
                    hit = 1;
                    break;
                end
                @(negedge CLOCK_50);
            end
            if (!hit) chk("mid_reach40", 0, 1);
        end
        #2 KEY[0] = 1'b0;
        #1;
        chk("mid_q", LEDR, 0);
        chk("mid_st", HEX5, T_BLANK);
        chk_rem("mid", 0);
        cycles(3);
        KEY[0] = 1'b1;
        cycles(3);
        chk("mid_idle", HEX5, T_BLANK);
        do_div("post_rst", 9, 3);

        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, 1023);
            b = $urandom_range(1, 31);
            do_div($sformatf("rnd%0d", k), a, b);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
